sun_sar_seq_nb: RTL
===================

// Module: sun_sar_seq_nb
// PURPOSE
//  Synchronous, parametrised SAR sequencer: clocked successor of the async SAR9B digital chain.
//  Drives the sample switch and clocked comparator, resolves NBITS by binary search,
//  drives split CDAC control (CP/CN), and returns the result on a valid/ready output.
//  Adds features the async chain lacks:
//   - programmable timing
//   - continuous mode
//   - comparator-metastability flag
//   - output overrun flag
// PARAMETERS
//  NBITS     9  resolution, legal 2..16
//  TSAMPLE   4  CK cycles CK_SAMPLE is high per conversion, >=1
//  CMP_WAIT  2  CK cycles CK_CMP is high before the decision is sampled, >=1
// PORTS
//  CK         in   1        sequencer clock, rising edge
//  RST        in   1        asynchronous reset, active high
//  EN         in   1        block enable; low aborts any conversion
//  START      in   1        single-cycle conversion request (honoured only in IDLE)
//  CONT       in   1        1: restart sampling immediately after each conversion
//  CMP_OP     in   1        comparator positive output
//  CMP_ON     in   1        comparator negative output
//  CK_SAMPLE  out  1        bootstrapped sample switch control, 1 = track
//  CK_CMP     out  1        comparator clock, 1 = evaluate, 0 = reset
//  CP         out  NBITS-1  P-side CDAC bit controls, MSB first
//  CN         out  NBITS-1  N-side CDAC bit controls, MSB first
//  DONE       out  1        1-cycle pulse when the last bit is resolved
//  DOUT       out  NBITS    conversion result, MSB = first decision
//  DVALID     out  1        DOUT holds unread data
//  DREADY     in   1        consumer accepts DOUT when DVALID&&DREADY
//  OVR        out  1        sticky: a result overwrote unread data
//  ERR        out  1        sticky: comparator unresolved at a decision point
//  CLR_FLAGS  in   1        synchronous clear of OVR and ERR
// BEHAVIOUR
//  Reset:
//   - state=IDLE.
//   - All outputs 0; CP=CN=0 (DAC at mid-scale).
//  FSM states:
//   - IDLE -> SAMPLE when EN && (START || CONT).
//   - SAMPLE: CK_SAMPLE=1 for TSAMPLE cycles; CP=CN=0; bit index k=NBITS-1; then -> CMP.
//   - CMP: CK_SAMPLE=0, CK_CMP=1 for CMP_WAIT cycles, then -> DEC.
//   - DEC (1 cycle, CK_CMP=0): decision d = CMP_OP && !CMP_ON.
//      - If CMP_OP==CMP_ON: d=0 and ERR<=1.
//      - DOUT-shadow bit k <= d.
//      - If k>=1: CP[k-1]<=d and CN[k-1]<=!d.
//      - k==0 -> OUT; else k<=k-1 and -> CMP.
//   - OUT (1 cycle): DONE=1, the result is loaded into DOUT, DVALID=1.
//      - Next state: SAMPLE if EN&&CONT, else IDLE.
//  Latency:
//   - START sampled high -> DONE/DVALID high after TSAMPLE + NBITS*(CMP_WAIT+1) + 1 cycles.
//   - Defaults: 4+27+1 = 32.
//  CDAC:
//   - Unresolved bits stay CP=CN=0.
//   - Resolved bits hold until the next SAMPLE entry clears them.
//   - The LSB decision drives no DAC bit.
//  Output handshake:
//   - DVALID&&DREADY clears DVALID the next cycle.
//   - DOUT is stable while DVALID=1 unless overwritten.
//   - OUT while DVALID=1 && !DREADY: DOUT overwritten, DVALID stays 1, OVR<=1.
//   - OUT with DVALID&&DREADY same cycle: new data loaded, no OVR.
//  Abort and input rules:
//   - EN low in any non-IDLE state: -> IDLE next cycle.
//   - On abort: CK_SAMPLE=CK_CMP=0, CP=CN=0, no DONE.
//   - On abort: DOUT/DVALID/flags untouched.
//   - START outside IDLE ignored. START and CONT both high behave as CONT.
//  Flags and counters:
//   - CLR_FLAGS wins over a same-cycle set.
//   - Counters wrap nowhere: all are bounded by the parameters; widths via $clog2.
//  Async reset mid-conversion: immediate return to reset values, including DOUT/DVALID.
// STRUCTURE
//  sun_sar_pkg: state enum (IDLE,SAMPLE,CMP,DEC,OUT); function dac_update(k,d,cp,cn).
//  Sub-module sun_sar_outreg #(NBITS): DOUT/DVALID/DREADY holding register and OVR logic.
//  The sequencer FSM, counters and CDAC registers stay in this module.
// TESTING
//  1 NBITS=9, START once, comparator models SARP-SARN for input code 0x15A
//    -> DOUT=0x15A, DONE at cycle 32, CP/CN final = code[8:1] / ~code[8:1].
//  2 CONT=1, DREADY=1, 3 conversions with codes 0x000, 0x1FF, 0x100
//    -> DVALID pulses 32 cycles apart, exact codes, OVR=0.
//  3 CONT=1, DREADY=0 for 2 conversions
//    -> OVR=1 after the second; DOUT = second result; CLR_FLAGS -> OVR=0.
//  4 Comparator CMP_OP=CMP_ON=0 at bit 5 decision
//    -> ERR=1, DOUT[5]=0, conversion completes normally.
//  5 EN dropped during CMP of bit 3
//    -> IDLE next cycle, CK_CMP=0, CP=CN=0, no DONE; prior DVALID data intact.
//  6 RST asserted asynchronously mid-SAMPLE, NBITS=4/TSAMPLE=1/CMP_WAIT=1 build
//    -> all outputs 0 immediately; next START converts in 1+8+1=10 cycles.

Source files
------------

// File: rtl/sun_sar_pkg.sv
// Shared types and helpers for the clocked SAR sequencer.
// Holds the FSM state enum, width limits and the CDAC update function.
package sun_sar_pkg;

   localparam int SAR_NMAX = 16;
   localparam int SAR_CW   = SAR_NMAX - 1;
   localparam int SAR_KW   = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SAMPLE,
      S_CMP,
      S_DEC,
      S_OUT
   } sar_state_t;

   typedef struct packed {
      logic [SAR_CW-1:0] cp;
      logic [SAR_CW-1:0] cn;
   } dac_t;

   // Bit k drives DAC lane k-1; the LSB decision (k==0) has no lane.
   function automatic dac_t dac_update(
      input logic [SAR_KW-1:0] k,
      input logic              d,
      input logic [SAR_CW-1:0] cp,
      input logic [SAR_CW-1:0] cn
   );
      dac_t               r;
      logic [SAR_KW-1:0]  idx;
      r.cp = cp;
      r.cn = cn;
      idx  = k - SAR_KW'(1);
      if (k != '0) begin
         r.cp[idx] = d;
         r.cn[idx] = ~d;
      end
      return r;
   endfunction

endpackage

// File: rtl/sun_sar_outreg.sv
// Result holding register with valid/ready handshake and sticky overrun.
// Ports: clk_i, rst_i, load_i, data_i, ready_i, clr_i, dout_o, dvalid_o, ovr_o.
module sun_sar_outreg #(
   parameter int NBITS = 9
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [NBITS-1:0] data_i,
   input  logic             ready_i,
   input  logic             clr_i,
   output logic [NBITS-1:0] dout_o,
   output logic             dvalid_o,
   output logic             ovr_o
);

   logic [NBITS-1:0] dout_q, dout_d;
   logic             dvalid_q, dvalid_d;
   logic             ovr_q, ovr_d;

   always_comb begin
      dout_d   = dout_q;
      dvalid_d = dvalid_q;
      ovr_d    = ovr_q;
      if (dvalid_q && ready_i) begin
         dvalid_d = 1'b0;
      end
      if (load_i) begin
         dout_d   = data_i;
         dvalid_d = 1'b1;
         // unread data lost only if the consumer is not taking it now
         if (dvalid_q && !ready_i) begin
            ovr_d = 1'b1;
         end
      end
      if (clr_i) begin
         ovr_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dout_q   <= '0;
         dvalid_q <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         dout_q   <= dout_d;
         dvalid_q <= dvalid_d;
         ovr_q    <= ovr_d;
      end
   end

   assign dout_o   = dout_q;
   assign dvalid_o = dvalid_q;
   assign ovr_o    = ovr_q;

endmodule

// File: rtl/sun_sar_seq_nb.sv
// Clocked SAR sequencer: sample, binary search over NBITS, split CDAC drive.
// Ports: CK/RST, EN/START/CONT, CMP_OP/ON in; CK_SAMPLE/CK_CMP, CP/CN, DONE, DOUT/DVALID/DREADY, OVR/ERR, CLR_FLAGS.
module sun_sar_seq_nb #(
   parameter int NBITS    = 9,
   parameter int TSAMPLE  = 4,
   parameter int CMP_WAIT = 2
) (
   input  logic             CK,
   input  logic             RST,
   input  logic             EN,
   input  logic             START,
   input  logic             CONT,
   input  logic             CMP_OP,
   input  logic             CMP_ON,
   output logic             CK_SAMPLE,
   output logic             CK_CMP,
   output logic [NBITS-2:0] CP,
   output logic [NBITS-2:0] CN,
   output logic             DONE,
   output logic [NBITS-1:0] DOUT,
   output logic             DVALID,
   input  logic             DREADY,
   output logic             OVR,
   output logic             ERR,
   input  logic             CLR_FLAGS
);

   import sun_sar_pkg::*;

   localparam int KW   = $clog2(NBITS);
   localparam int TMAX = (TSAMPLE > CMP_WAIT) ? TSAMPLE : CMP_WAIT;
   localparam int CW   = $clog2(TMAX + 1);

   sar_state_t       state_q;
   logic [CW-1:0]    cnt_q;
   logic [KW-1:0]    k_q;
   logic [NBITS-1:0] res_q;
   logic [NBITS-2:0] cp_q, cn_q;
   logic             ck_sample_q, ck_cmp_q;
   logic             done_q, err_q;

   logic dec_d;
   logic load;
   dac_t dac_x;
   logic unused_dac;

   // an unresolved comparator (OP==ON) decodes as 0
   assign dec_d = CMP_OP & ~CMP_ON;
   assign load  = (state_q == S_OUT) && EN;

   always_comb begin
      dac_x = dac_update(SAR_KW'(k_q), dec_d,
                         SAR_CW'(cp_q), SAR_CW'(cn_q));
   end

   // lanes above NBITS-2 are don't-care
   assign unused_dac = ^dac_x;

   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         k_q         <= '0;
         res_q       <= '0;
         cp_q        <= '0;
         cn_q        <= '0;
         ck_sample_q <= 1'b0;
         ck_cmp_q    <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q != S_IDLE && !EN) begin
            state_q     <= S_IDLE;
            ck_sample_q <= 1'b0;
            ck_cmp_q    <= 1'b0;
            cp_q        <= '0;
            cn_q        <= '0;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  if (EN && (START || CONT)) begin
                     state_q     <= S_SAMPLE;
                     ck_sample_q <= 1'b1;
                     cnt_q       <= '0;
                     k_q         <= KW'(NBITS - 1);
                     cp_q        <= '0;
                     cn_q        <= '0;
                  end
               end
               S_SAMPLE: begin
                  if (cnt_q == CW'(TSAMPLE - 1)) begin
                     state_q     <= S_CMP;
                     ck_sample_q <= 1'b0;
                     ck_cmp_q    <= 1'b1;
                     cnt_q       <= '0;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               S_CMP: begin
                  if (cnt_q == CW'(CMP_WAIT - 1)) begin
                     state_q  <= S_DEC;
                     ck_cmp_q <= 1'b0;
                     cnt_q    <= '0;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               S_DEC: begin
                  res_q[k_q] <= dec_d;
                  cp_q       <= dac_x.cp[NBITS-2:0];
                  cn_q       <= dac_x.cn[NBITS-2:0];
                  if (CMP_OP == CMP_ON) begin
                     err_q <= 1'b1;
                  end
                  if (k_q == '0) begin
                     state_q <= S_OUT;
                  end else begin
                     k_q      <= k_q - KW'(1);
                     state_q  <= S_CMP;
                     ck_cmp_q <= 1'b1;
                  end
               end
               S_OUT: begin
                  done_q <= 1'b1;
                  if (CONT) begin
                     state_q     <= S_SAMPLE;
                     ck_sample_q <= 1'b1;
                     cnt_q       <= '0;
                     k_q         <= KW'(NBITS - 1);
                     cp_q        <= '0;
                     cn_q        <= '0;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            endcase
         end
         if (CLR_FLAGS) begin
            err_q <= 1'b0;
         end
      end
   end

   sun_sar_outreg #(
      .NBITS(NBITS)
   ) u_outreg (
      .clk_i   (CK),
      .rst_i   (RST),
      .load_i  (load),
      .data_i  (res_q),
      .ready_i (DREADY),
      .clr_i   (CLR_FLAGS),
      .dout_o  (DOUT),
      .dvalid_o(DVALID),
      .ovr_o   (OVR)
   );

   assign CK_SAMPLE = ck_sample_q;
   assign CK_CMP    = ck_cmp_q;
   assign CP        = cp_q;
   assign CN        = cn_q;
   assign DONE      = done_q;
   assign ERR       = err_q;

endmodule
